// File: rtl/vga_screen_render.sv
`default_nettype none
// ============================================================================
//  Module   : vga_screen_render
//  Purpose  : Renders the 512x256 one-bit Hack screen, read from a screen RAM
//             of 16-bit words, as a centred window inside a VGA frame. The
//             area outside the window is filled with a border colour. Colours
//             and the invert flag are sampled once per frame.
//  Revision : 1.0
// ============================================================================

`ifndef H_SIZE
`define H_SIZE 10
`endif
`ifndef V_SIZE
`define V_SIZE 10
`endif

module vga_screen_render #(
   parameter int RGB_WIDTH   = 10,
   parameter int RAM_LATENCY = 1,
   parameter int H_OFFSET    = 64,
   parameter int V_OFFSET    = 112
) (
   input  logic                     pixel_clk,
   input  logic                     reset,
   input  logic                     vga_hsync,
   input  logic                     vga_vsync,
   input  logic                     video_on,
   input  logic [`H_SIZE-1:0]       x_addr,
   input  logic [`V_SIZE-1:0]       y_addr,
   input  logic [3*RGB_WIDTH-1:0]   fg_color,
   input  logic [3*RGB_WIDTH-1:0]   bg_color,
   input  logic [3*RGB_WIDTH-1:0]   border_color,
   input  logic                     invert,
   output logic                     hsync,
   output logic                     vsync,
   output logic [RGB_WIDTH-1:0]     r,
   output logic [RGB_WIDTH-1:0]     g,
   output logic [RGB_WIDTH-1:0]     b,
   output logic [15:0]              ram_addr,
   output logic                     ram_en,
   input  logic [15:0]              ram_rdata
);

   // Reject parameter sets that cannot be built correctly.
   generate
      if (RAM_LATENCY < 1 || RAM_LATENCY > 4) begin : g_bad_latency
         $error("vga_screen_render: RAM_LATENCY must be in 1..4");
      end
      if (RGB_WIDTH < 1) begin : g_bad_rgb
         $error("vga_screen_render: RGB_WIDTH must be at least 1");
      end
      if (H_OFFSET < 0 || (H_OFFSET + 512) > (1 << `H_SIZE)) begin : g_bad_h
         $error("vga_screen_render: horizontal window exceeds x_addr range");
      end
      if (V_OFFSET < 0 || (V_OFFSET + 256) > (1 << `V_SIZE)) begin : g_bad_v
         $error("vga_screen_render: vertical window exceeds y_addr range");
      end
   endgenerate

   typedef logic [`H_SIZE-1:0]     hpos_t;
   typedef logic [`V_SIZE-1:0]     vpos_t;
   typedef logic [3*RGB_WIDTH-1:0] color_t;

   // Per-pixel context that travels alongside the RAM read.
   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       von;
      logic       win;
      logic [3:0] lx;
      logic       en;
      logic       start;
   } stage_t;

   hpos_t  lx_full;
   vpos_t  ly_full;
   logic   in_win;
   logic   frame_start;
   stage_t stage_in;
   stage_t pipe [RAM_LATENCY];
   stage_t last;

   logic [15:0] word_reg;
   logic [15:0] word;
   logic        pix;

   color_t fg_q, bg_q, border_q;
   logic   invert_q;
   color_t fg_act, bg_act, border_act;
   logic   invert_act;
   color_t fg_cur, bg_cur, border_cur;
   logic   invert_cur;

   // Window decode and RAM address generation. The subtraction wraps for
   // x/y below the offset, so the lower bound is checked separately.
   always_comb begin
      lx_full     = x_addr - hpos_t'(H_OFFSET);
      ly_full     = y_addr - vpos_t'(V_OFFSET);
      in_win      = video_on
                    && (x_addr >= hpos_t'(H_OFFSET)) && (lx_full[`H_SIZE-1:9] == '0)
                    && (y_addr >= vpos_t'(V_OFFSET)) && (ly_full[`V_SIZE-1:8] == '0);
      frame_start = (x_addr == '0) && (y_addr == '0);
      ram_en      = !reset && in_win && (lx_full[3:0] == 4'd0);
      ram_addr    = (!reset && in_win) ? {3'b000, ly_full[7:0], lx_full[8:4]} : 16'd0;
      stage_in.hs    = vga_hsync;
      stage_in.vs    = vga_vsync;
      stage_in.von   = video_on;
      stage_in.win   = in_win;
      stage_in.lx    = lx_full[3:0];
      stage_in.en    = ram_en;
      stage_in.start = frame_start;
   end

   // Delay line matching the screen RAM read latency.
   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         for (int i = 0; i < RAM_LATENCY; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= stage_in;
         for (int i = 1; i < RAM_LATENCY; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign last = pipe[RAM_LATENCY-1];

   // Hold the fetched word for the remaining 15 pixels of its group.
   always_ff @(posedge pixel_clk) begin
      if (reset)        word_reg <= '0;
      else if (last.en) word_reg <= ram_rdata;
   end

   // Frame-start shadow copy of the colour and invert inputs.
   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         fg_q     <= '0;
         bg_q     <= '1;
         border_q <= '0;
         invert_q <= 1'b0;
      end else if (frame_start) begin
         fg_q     <= fg_color;
         bg_q     <= bg_color;
         border_q <= border_color;
         invert_q <= invert;
      end
   end

   // Shadows take effect only when pixel (0,0) reaches the output stage, so
   // pixels already in flight at the load keep the previous frame's values.
   always_comb begin
      fg_cur     = last.start ? fg_q     : fg_act;
      bg_cur     = last.start ? bg_q     : bg_act;
      border_cur = last.start ? border_q : border_act;
      invert_cur = last.start ? invert_q : invert_act;
      word       = last.en ? ram_rdata : word_reg;
      pix        = word[last.lx] ^ invert_cur;
   end

   // Colour set currently applied at the output stage.
   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         fg_act     <= '0;
         bg_act     <= '1;
         border_act <= '0;
         invert_act <= 1'b0;
      end else begin
         fg_act     <= fg_cur;
         bg_act     <= bg_cur;
         border_act <= border_cur;
         invert_act <= invert_cur;
      end
   end

   // Output register: colour select and delayed syncs.
   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         hsync     <= 1'b0;
         vsync     <= 1'b0;
         {r, g, b} <= '0;
      end else begin
         hsync <= last.hs;
         vsync <= last.vs;
         if (!last.von)    {r, g, b} <= '0;
         else if (last.win) {r, g, b} <= pix ? fg_cur : bg_cur;
         else              {r, g, b} <= border_cur;
      end
   end

endmodule

`default_nettype wire
